// File: rtl/keypad_scan.sv
// keypad_scan: 3x4 matrix keypad scanner with press/release debounce and a 2-entry key FIFO.
// Define KEYPAD_REPEAT_EN to auto-repeat a held key.
module keypad_scan #(
  parameter int SCAN_DIV     = 25000,
  parameter int DEBOUNCE_CNT = 250000,
  parameter int REPEAT_DELAY = 25000000,
  parameter int REPEAT_RATE  = 5000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] keypadCol,
  output logic [2:0] keypadRow,
  output logic [3:0] key_code,
  output logic       key_valid,
  input  logic       key_ready,
  output logic       overflow
);
  localparam int DIV_W = $clog2(SCAN_DIV + 1);
  localparam int DEB_W = $clog2(DEBOUNCE_CNT + 1);
  localparam logic [DIV_W-1:0] DIV_LAST = DIV_W'(SCAN_DIV - 1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEBOUNCE_CNT - 1);

  typedef enum logic [1:0] {SCAN, DEBOUNCE, HELD, RELEASE} stateType;

  stateType         state, stateNext;
  logic [2:0]       rowReg, rowNext;
  logic [DIV_W-1:0] divCnt, divNext;
  logic [DEB_W-1:0] debCnt, debNext;
  logic [3:0]       codeReg, codeNext;
  logic [3:0]       colReg, colNext;
  logic [4:0]       sample;
  logic             pushKey;
  logic             popKey;
  logic             repeatFire;
  logic [3:0]       tailCode;
  logic             tailValid;

  function automatic logic [2:0] advanceRow(input logic [2:0] row);
    case (row)
      3'b110:  return 3'b101;
      3'b101:  return 3'b011;
      default: return 3'b110;
    endcase
  endfunction

  // Returns {hit, code}; hit is low for unmapped rows or column patterns.
  function automatic logic [4:0] decodeKey(input logic [2:0] row, input logic [3:0] col);
    logic [3:0] base;
    logic [3:0] extra;
    logic       hit;
    base  = 4'd0;
    extra = 4'd0;
    hit   = 1'b1;
    case (row)
      3'b110:  begin base = 4'd1; extra = 4'd10; end
      3'b101:  begin base = 4'd4; extra = 4'd11; end
      3'b011:  begin base = 4'd7; extra = 4'd0;  end
      default: hit = 1'b0;
    endcase
    case (col)
      4'b1110: return {hit, base};
      4'b1101: return {hit, base + 4'd1};
      4'b1011: return {hit, base + 4'd2};
      4'b0111: return {hit, extra};
      default: return 5'd0;
    endcase
  endfunction

`ifdef KEYPAD_REPEAT_EN
  localparam int REP_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
  localparam int REP_W   = $clog2(REP_MAX + 1);
  localparam logic [REP_W-1:0] DELAY_LAST = REP_W'(REPEAT_DELAY - 1);
  localparam logic [REP_W-1:0] RATE_LAST  = REP_W'(REPEAT_RATE - 1);

  logic [REP_W-1:0] repCnt;
  logic             repeating;

  assign repeatFire = (state == HELD) && (keypadCol != 4'b1111) &&
                      (repCnt == (repeating ? RATE_LAST : DELAY_LAST));

  // The timer only advances in HELD, so a release bounce pauses it rather than restarting it.
  always_ff @(posedge clk) begin
    if (!rst) begin
      repCnt    <= '0;
      repeating <= 1'b0;
    end else if (state == DEBOUNCE) begin
      repCnt    <= '0;
      repeating <= 1'b0;
    end else if (repeatFire) begin
      repCnt    <= '0;
      repeating <= 1'b1;
    end else if ((state == HELD) && (repCnt != '1)) begin
      repCnt <= repCnt + 1'b1;
    end
  end
`else
  assign repeatFire = 1'b0;
`endif

  always_comb begin
    stateNext = state;
    rowNext   = rowReg;
    divNext   = divCnt;
    debNext   = debCnt;
    codeNext  = codeReg;
    colNext   = colReg;
    pushKey   = repeatFire;
    sample    = decodeKey(rowReg, keypadCol);
    case (state)
      SCAN: begin
        if (divCnt >= DIV_LAST) begin
          divNext = '0;
          if (sample[4]) begin
            codeNext  = sample[3:0];
            colNext   = keypadCol;
            debNext   = '0;
            stateNext = DEBOUNCE;
          end else begin
            rowNext = advanceRow(rowReg);
          end
        end else begin
          divNext = divCnt + 1'b1;
        end
      end
      DEBOUNCE: begin
        if (keypadCol != colReg) begin
          stateNext = SCAN;
          rowNext   = advanceRow(rowReg);
          divNext   = '0;
        end else if (debCnt >= DEB_LAST) begin
          pushKey   = 1'b1;
          stateNext = HELD;
        end else begin
          debNext = debCnt + 1'b1;
        end
      end
      HELD: begin
        if (keypadCol == 4'b1111) begin
          stateNext = RELEASE;
          debNext   = '0;
        end
      end
      RELEASE: begin
        if (keypadCol != 4'b1111) begin
          stateNext = HELD;
        end else if (debCnt >= DEB_LAST) begin
          stateNext = SCAN;
          rowNext   = advanceRow(rowReg);
          divNext   = '0;
        end else begin
          debNext = debCnt + 1'b1;
        end
      end
      default: stateNext = SCAN;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state   <= SCAN;
      rowReg  <= 3'b110;
      divCnt  <= '0;
      debCnt  <= '0;
      codeReg <= 4'd0;
      colReg  <= 4'b1111;
    end else begin
      state   <= stateNext;
      rowReg  <= rowNext;
      divCnt  <= divNext;
      debCnt  <= debNext;
      codeReg <= codeNext;
      colReg  <= colNext;
    end
  end

  assign keypadRow = rowReg;
  assign popKey    = key_valid && key_ready;

  // Head register drives the outputs directly; the tail holds the second entry.
  always_ff @(posedge clk) begin
    if (!rst) begin
      key_code  <= 4'd0;
      key_valid <= 1'b0;
      tailCode  <= 4'd0;
      tailValid <= 1'b0;
      overflow  <= 1'b0;
    end else begin
      overflow <= pushKey && tailValid && !popKey;
      if (popKey) begin
        if (tailValid) begin
          key_code <= tailCode;
          if (pushKey) tailCode <= codeReg;
          else         tailValid <= 1'b0;
        end else if (pushKey) begin
          key_code <= codeReg;
        end else begin
          key_valid <= 1'b0;
        end
      end else if (pushKey) begin
        if (!key_valid) begin
          key_code  <= codeReg;
          key_valid <= 1'b1;
        end else if (!tailValid) begin
          tailCode  <= codeReg;
          tailValid <= 1'b1;
        end
      end
    end
  end
endmodule

// File: tb/tb_keypad_scan.sv
// Bench for keypad_scan: emulates a 3x4 key matrix on the row/column lines and
// scores the key stream against the keypad's code map.
`timescale 1ns/1ps
module tb_keypad_scan;
  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] keypadCol;
  logic [2:0] keypadRow;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_ready;
  logic       overflow;

  logic       keyDown;
  logic       forceOn;
  logic [3:0] forceCol;
  logic [2:0] rowSel;
  logic [3:0] colSel;

  int errors = 0;
  int checks = 0;
  int cycle  = 0;
  int popCount;
  logic lastHeld;
  logic [3:0] lastCode;
  int codeMap[3][4];
  logic [3:0] expQ[$];

  typedef struct {
    int row;
    int col;
    int expCode;
    int expBeat;
  } keyVec;
  keyVec vectors[12];

  always #5 clk = ~clk;

  // A pressed key pulls its column low only while its row is driven low.
  assign keypadCol = forceOn ? forceCol :
                     (keyDown && (keypadRow == rowSel)) ? colSel : 4'b1111;

  keypad_scan #(
    .SCAN_DIV(4), .DEBOUNCE_CNT(8), .REPEAT_DELAY(40), .REPEAT_RATE(10)
  ) dut (
    .clk(clk), .rst(rst), .keypadCol(keypadCol), .keypadRow(keypadRow),
    .key_code(key_code), .key_valid(key_valid), .key_ready(key_ready),
    .overflow(overflow)
  );

  function automatic logic [2:0] rowPat(input int r);
    return (r == 0) ? 3'b110 : (r == 1) ? 3'b101 : 3'b011;
  endfunction

  task automatic stepCycle();
    @(posedge clk);
    #1;
    cycle++;
  endtask

  task automatic stepTo(input int n);
    while (cycle < n) stepCycle();
  endtask

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0d, expected %0d (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic applyStimulus(input int row, input int col, input logic down, input logic ready);
    rowSel    = rowPat(row);
    colSel    = ~(4'b0001 << col);
    keyDown   = down;
    key_ready = ready;
  endtask

  task automatic doReset();
    rst       = 1'b0;
    keyDown   = 1'b0;
    forceOn   = 1'b0;
    key_ready = 1'b0;
    stepCycle();
    stepCycle();
    checkOutput("reset keypadRow", keypadRow, 3'b110);
    checkOutput("reset key_valid", key_valid, 0);
    checkOutput("reset key_code", key_code, 0);
    checkOutput("reset overflow", overflow, 0);
    rst   = 1'b1;
    cycle = 0;
  endtask

  task automatic randomTick(input logic drain);
    key_ready = drain ? 1'b1 : ($urandom_range(0, 3) != 0);
    if (lastHeld && key_valid) checkOutput("rand head stable", key_code, lastCode);
    if (key_valid && key_ready) begin
      popCount++;
      if (expQ.size() == 0) checkOutput("rand spurious pop", key_code, -1);
      else checkOutput("rand pop code", key_code, expQ.pop_front());
    end
    checkOutput("rand overflow", overflow, 0);
    lastHeld = key_valid && !key_ready;
    lastCode = key_code;
    stepCycle();
  endtask

  initial begin
    int beats;
    int beatCycle;
    int beatCode;
    int ovPulses;
    int beatQ[$];
    int expBeats[$];

    rst = 1'b0; key_ready = 1'b0; keyDown = 1'b0; forceOn = 1'b0;
    forceCol = 4'b1011; rowSel = 3'b110; colSel = 4'b1111;
    codeMap = '{'{1, 2, 3, 10}, '{4, 5, 6, 11}, '{7, 8, 9, 0}};
    vectors = '{'{0, 0, 1, 12}, '{0, 1, 2, 12}, '{0, 2, 3, 12}, '{0, 3, 10, 12},
                '{1, 0, 4, 16}, '{1, 1, 5, 16}, '{1, 2, 6, 16}, '{1, 3, 11, 16},
                '{2, 0, 7, 20}, '{2, 1, 8, 20}, '{2, 2, 9, 20}, '{2, 3, 0, 20}};

    // Idle rotation: four cycles per row.
    doReset();
    for (int t = 1; t <= 24; t++) begin
      stepCycle();
      checkOutput("idle rotation", keypadRow, rowPat((t / 4) % 3));
      checkOutput("idle key_valid", key_valid, 0);
    end

    // Key map and latency for every key position.
    for (int i = 0; i < 12; i++) begin
      doReset();
      applyStimulus(vectors[i].row, vectors[i].col, 1'b1, 1'b1);
      beats = 0; beatCycle = -1; beatCode = -1;
      while (cycle < 40) begin
        stepCycle();
        if (cycle == 30) keyDown = 1'b0;
        if (key_valid) begin
          beats++;
          beatCycle = cycle;
          beatCode  = key_code;
        end
      end
      checkOutput($sformatf("map r%0dc%0d beats", vectors[i].row, vectors[i].col), beats, 1);
      checkOutput($sformatf("map r%0dc%0d code", vectors[i].row, vectors[i].col), beatCode, vectors[i].expCode);
      checkOutput($sformatf("map r%0dc%0d latency", vectors[i].row, vectors[i].col), beatCycle, vectors[i].expBeat);
    end

    // Key 5: one beat 9 cycles after the sample, row frozen through the release debounce.
    doReset();
    applyStimulus(1, 1, 1'b1, 1'b1);
    while (cycle < 25) begin
      stepCycle();
      checkOutput("press5 key_valid", key_valid, (cycle == 16));
      if (cycle == 16) checkOutput("press5 key_code", key_code, 5);
      if (cycle >= 4) checkOutput("press5 row frozen", keypadRow, 3'b101);
    end
    keyDown = 1'b0;
    while (cycle < 40) begin
      stepCycle();
      checkOutput("release row", keypadRow, (cycle <= 33) ? 3'b101 : (cycle <= 37) ? 3'b011 : 3'b110);
      checkOutput("release key_valid", key_valid, 0);
    end

    // Three-cycle glitch across the row-110 sample point.
    doReset();
    key_ready = 1'b1;
    while (cycle < 30) begin
      stepCycle();
      forceOn = (cycle <= 3);
      if (cycle == 4) checkOutput("glitch debounce row", keypadRow, 3'b110);
      if (cycle == 5) checkOutput("glitch resume row", keypadRow, 3'b101);
      if (cycle == 9) checkOutput("glitch next row", keypadRow, 3'b011);
      checkOutput("glitch key_valid", key_valid, 0);
    end
    forceOn = 1'b0;

    // Keys 1, 2, 3 with the consumer stalled: third key overflows.
    doReset();
    ovPulses = 0;
    for (int k = 0; k < 3; k++) begin
      applyStimulus(0, k, 1'b1, 1'b0);
      for (int n = 0; n < 50; n++) begin
        stepCycle();
        if (n == 30) keyDown = 1'b0;
        if (overflow) ovPulses++;
        if (key_valid) checkOutput("stalled head code", key_code, 1);
      end
    end
    checkOutput("overflow pulses", ovPulses, 1);
    checkOutput("full head valid", key_valid, 1);
    checkOutput("full head code", key_code, 1);
    key_ready = 1'b1;
    stepCycle();
    checkOutput("second pop valid", key_valid, 1);
    checkOutput("second pop code", key_code, 2);
    stepCycle();
    key_ready = 1'b0;
    checkOutput("drained valid", key_valid, 0);

    // Reset in the middle of a debounce with key 1 queued.
    doReset();
    applyStimulus(0, 0, 1'b1, 1'b0);
    stepTo(15);
    keyDown = 1'b0;
    stepTo(20);
    applyStimulus(1, 1, 1'b1, 1'b0);
    stepTo(29);
    checkOutput("pre-reset row", keypadRow, 3'b101);
    checkOutput("pre-reset queued valid", key_valid, 1);
    checkOutput("pre-reset queued code", key_code, 1);
    stepTo(30);
    rst = 1'b0;
    stepCycle();
    rst = 1'b1;
    keyDown = 1'b0;
    key_ready = 1'b1;
    checkOutput("mid-debounce reset valid", key_valid, 0);
    checkOutput("mid-debounce reset row", keypadRow, 3'b110);
    checkOutput("mid-debounce reset code", key_code, 0);
    for (int n = 0; n < 40; n++) begin
      stepCycle();
      checkOutput("no late push", key_valid, 0);
    end

    // Key 0 held for 70 cycles.
    doReset();
    applyStimulus(2, 3, 1'b1, 1'b1);
    beatQ.delete();
    while (cycle < 100) begin
      stepCycle();
      if (cycle == 70) keyDown = 1'b0;
      if (key_valid) begin
        beatQ.push_back(cycle);
        checkOutput("hold0 code", key_code, 0);
      end
    end
`ifdef KEYPAD_REPEAT_EN
    expBeats = '{20, 60, 70};
`else
    expBeats = '{20};
`endif
    checkOutput("hold0 beat count", beatQ.size(), expBeats.size());
    for (int i = 0; i < expBeats.size(); i++)
      if (i < beatQ.size()) checkOutput($sformatf("hold0 beat %0d cycle", i), beatQ[i], expBeats[i]);

    // Random presses with a random consumer, scored in press order.
    doReset();
    expQ.delete();
    popCount = 0;
    lastHeld = 1'b0;
    lastCode = 4'd0;
    for (int p = 0; p < 16; p++) begin
      int r;
      int c;
      int idle;
      int hold;
      r    = $urandom_range(0, 2);
      c    = $urandom_range(0, 3);
      idle = $urandom_range(15, 30);
      hold = $urandom_range(25, 35);
      applyStimulus(r, c, 1'b0, key_ready);
      for (int n = 0; n < idle; n++) randomTick(1'b0);
      keyDown = 1'b1;
      expQ.push_back(4'(codeMap[r][c]));
      for (int n = 0; n < hold; n++) randomTick(1'b0);
      keyDown = 1'b0;
    end
    for (int n = 0; n < 40; n++) randomTick(1'b0);
    for (int n = 0; n < 20; n++) randomTick(1'b1);
    checkOutput("rand leftover", expQ.size(), 0);
    checkOutput("rand pops", popCount, 16);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
